// File: rtl/ext_pipe.sv
// ext_pipe: immediate extender feeding a 2-entry output stage (output register + skid buffer).
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [CNT_W-1:0] acc_cnt
);
    localparam int PAD = OUT_W - IN_W;
    localparam int IW  = OUT_W + TAG_W + 1;
    logic [OUT_W-1:0] sext, ext_imm;
    logic [IW-1:0] new_item, out_item_q, out_item_d, skid_item_q, skid_item_d;
    logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_fire, out_fire;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    always_comb begin
        sext = {{PAD{in_imm[IN_W-1]}}, in_imm};
        ext_imm = (in_op == 3'b001) ? {{PAD{1'b0}}, in_imm} :
                  (in_op == 3'b010) ? {in_imm, {PAD{1'b0}}} :
                  (in_op == 3'b011) ? sext << 2 :
                  (in_op == 3'b100) ? {{PAD{1'b1}}, in_imm} :
                  (in_op == 3'b101) ? sext << 1 : sext;
        new_item = {ext_imm, in_tag, in_op[2] & in_op[1]};
    end
    // A skid item always moves forward before a new item can land behind it.
    always_comb begin
        in_fire = in_valid && !skid_valid_q;
        out_fire = out_valid_q && out_ready;
        out_valid_d = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_item_d = out_item_q;
        skid_item_d = skid_item_q;
        acc_cnt_d = acc_cnt_q + CNT_W'(in_fire);
        if (flush) begin
            out_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (out_fire) begin
                out_valid_d = skid_valid_q;
                out_item_d = skid_item_q;
                skid_valid_d = 1'b0;
            end
            if (in_fire && (!out_valid_q || out_fire)) begin
                out_valid_d = 1'b1;
                out_item_d = new_item;
            end else if (in_fire) begin
                skid_valid_d = 1'b1;
                skid_item_d = new_item;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            out_item_q <= '0;
            skid_item_q <= '0;
            acc_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_item_q <= out_item_d;
            skid_item_q <= skid_item_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end
    assign in_ready = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign {out_imm, out_tag, out_err} = out_item_q;
    assign acc_cnt = acc_cnt_q;
endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: scoreboard bench for ext_pipe; a forked monitor pushes on input handshakes and pops on output handshakes.
module tb_ext_pipe;
    logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] in_imm = '0;
    logic [2:0] in_op = '0;
    logic [4:0] in_tag = '0;
    logic in_ready, out_valid, out_err, in_ready4, out_valid4, out_err4;
    logic [31:0] out_imm, out_imm4;
    logic [4:0] out_tag, out_tag4;
    logic [15:0] acc_cnt;
    logic [3:0] acc_cnt4;
    typedef struct packed {logic [31:0] imm; logic [4:0] tag; logic err;} item_t;
    item_t sb[$];
    item_t got, prev, want;
    int total = 0, bad = 0, cyc = 0;
    logic prev_stall = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_imm = '0;
    logic [31:0] ev [6] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004, 32'hFFFF8001, 32'hFFFF0002};

    ext_pipe dut (.clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_op(in_op), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag), .out_err(out_err), .acc_cnt(acc_cnt));
    ext_pipe #(.CNT_W(4)) u4 (.clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
        .in_imm(in_imm), .in_op(in_op), .in_tag(in_tag), .out_valid(out_valid4), .out_ready(out_ready),
        .out_imm(out_imm4), .out_tag(out_tag4), .out_err(out_err4), .acc_cnt(acc_cnt4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic monitor();
        forever begin
            @(negedge clk);
            got = {out_imm, out_tag, out_err};
            if (reset || flush) begin
                sb.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    total++;
                    if (!out_valid || got !== prev) begin
                        bad++;
                        $display("FAIL stall_hold: got v=%b %h/%0d/%b required v=1 %h/%0d/%b", out_valid, got.imm, got.tag, got.err, prev.imm, prev.tag, prev.err);
                    end
                end
                if (out_valid && out_ready) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL sb_extra: got %h tag %0d required no item", got.imm, got.tag);
                    end else begin
                        want = sb.pop_front();
                        if (got !== want) begin
                            bad++;
                            $display("FAIL sb_order: got %h/%0d/%b required %h/%0d/%b", got.imm, got.tag, got.err, want.imm, want.tag, want.err);
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    sb.push_back({exp_imm, in_tag, exp_err});
                    total++;
                    if (sb.size() > 2) begin
                        bad++;
                        $display("FAIL occupancy: got %0d held items required at most 2", sb.size());
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev = got;
            end
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [15:0] imm, input logic [4:0] tag, input logic [31:0] eimm, input logic eerr);
        int n = 0;
        in_op = op; in_imm = imm; in_tag = tag; exp_imm = eimm; exp_err = eerr; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL send_timeout: in_ready=%b required 1 (tag %0d)", in_ready, tag);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        #1 reset = 1'b0;
        sb.delete();
        prev_stall = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++;
        if ({out_valid, in_ready, out_err} !== 3'b010) begin
            bad++;
            $display("FAIL reset_flags: got v/r/e=%b%b%b required 010", out_valid, in_ready, out_err);
        end
        total++;
        if ({out_imm, out_tag, acc_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_data: got imm=%h tag=%0d cnt=%0d required 0", out_imm, out_tag, acc_cnt);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_ops();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(3'(i), 16'h8001, 5'(i), ev[i], 1'b0);
            total++;
            if ({out_valid, out_imm, out_tag, out_err} !== {1'b1, ev[i], 5'(i), 1'b0}) begin
                bad++;
                $display("FAIL op%0d: got v=%b %h/%0d/%b required v=1 %h/%0d/0", i, out_valid, out_imm, out_tag, out_err, ev[i], i);
            end
        end
    endtask

    task automatic test_err();
        out_ready = 1'b1;
        for (int i = 6; i < 8; i++) begin
            send(3'(i), 16'h7FFF, 5'(10 + i), 32'h00007FFF, 1'b1);
            total++;
            if ({out_valid, out_imm, out_err} !== {1'b1, 32'h00007FFF, 1'b1}) begin
                bad++;
                $display("FAIL err_op%0d: got v=%b %h err=%b required v=1 00007fff err=1", i, out_valid, out_imm, out_err);
            end
        end
    endtask

    task automatic test_backpressure();
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        send(3'b001, 16'h00A1, 5'd1, 32'h000000A1, 1'b0);
        send(3'b001, 16'h00A2, 5'd2, 32'h000000A2, 1'b0);
        total++;
        if ({in_ready, out_valid, out_tag} !== {1'b0, 1'b1, 5'd1}) begin
            bad++;
            $display("FAIL bp_full: got r=%b v=%b tag=%0d required r=0 v=1 tag=1", in_ready, out_valid, out_tag);
        end
        in_op = 3'b001; in_imm = 16'h00A3; in_tag = 5'd3; exp_imm = 32'h000000A3; exp_err = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({in_ready, out_tag} !== {1'b0, 5'd1}) begin
                bad++;
                $display("FAIL bp_hold: got r=%b tag=%0d required r=0 tag=1", in_ready, out_tag);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(3'b001, 16'h00A3, 5'd3, 32'h000000A3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL bp_drain: got %0d items outstanding required 0", sb.size());
        end
    endtask

    task automatic test_stream();
        int c0;
        do_reset();
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 100; i++) send(3'b001, 16'(i * 7), 5'(i), {16'h0, 16'(i * 7)}, 1'b0);
        total++;
        if (cyc - c0 != 100) begin
            bad++;
            $display("FAIL stream_rate: got %0d cycles required 100", cyc - c0);
        end
        @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0 || acc_cnt !== 16'd100) begin
            bad++;
            $display("FAIL stream_count: got left=%0d cnt=%0d required left=0 cnt=100", sb.size(), acc_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(3'b000, 16'(i), 5'(i), {16'h0, 16'(i)}, 1'b0);
        total++;
        if ({out_valid4, in_ready4, out_imm4, out_tag4, out_err4} !== {1'b1, 1'b1, 32'd16, 5'd16, 1'b0}) begin
            bad++;
            $display("FAIL cnt4_item: got v=%b r=%b %h/%0d/%b required v=1 r=1 00000010/16/0", out_valid4, in_ready4, out_imm4, out_tag4, out_err4);
        end
        @(posedge clk);
        #1;
        total++;
        if (acc_cnt4 !== 4'd1 || acc_cnt !== 16'd17) begin
            bad++;
            $display("FAIL cnt_wrap: got cnt4=%0d cnt=%0d required cnt4=1 cnt=17", acc_cnt4, acc_cnt);
        end
    endtask

    task automatic test_flush_reset();
        do_reset();
        out_ready = 1'b0;
        send(3'b001, 16'h0014, 5'd20, 32'h14, 1'b0);
        send(3'b001, 16'h0015, 5'd21, 32'h15, 1'b0);
        total++;
        if ({in_ready, out_valid} !== 2'b01) begin
            bad++;
            $display("FAIL flush_pre: got r=%b v=%b required r=0 v=1", in_ready, out_valid);
        end
        flush = 1'b1; in_valid = 1'b1; in_tag = 5'd30;
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, in_ready, acc_cnt} !== {1'b0, 1'b1, 16'd2}) begin
            bad++;
            $display("FAIL flush_edge: got v=%b r=%b cnt=%0d required v=0 r=1 cnt=2", out_valid, in_ready, acc_cnt);
        end
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, in_ready, acc_cnt} !== {1'b0, 1'b1, 16'd3}) begin
            bad++;
            $display("FAIL flush_hs: got v=%b r=%b cnt=%0d required v=0 r=1 cnt=3", out_valid, in_ready, acc_cnt);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        send(3'b000, 16'h1234, 5'd22, 32'h00001234, 1'b0);
        total++;
        if ({out_valid, out_tag} !== {1'b1, 5'd22}) begin
            bad++;
            $display("FAIL flush_after: got v=%b tag=%0d required v=1 tag=22", out_valid, out_tag);
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(3'b001, 16'h0017, 5'd23, 32'h17, 1'b0);
        send(3'b001, 16'h0018, 5'd24, 32'h18, 1'b0);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({out_valid, in_ready, out_imm, out_tag, out_err, acc_cnt} !== {1'b0, 1'b1, 32'h0, 5'h0, 1'b0, 16'h0}) begin
            bad++;
            $display("FAIL async_reset: got v=%b r=%b %h/%0d/%b cnt=%0d required v=0 r=1 0/0/0 cnt=0", out_valid, in_ready, out_imm, out_tag, out_err, acc_cnt);
        end
        reset = 1'b0;
        sb.delete();
        prev_stall = 1'b0;
        out_ready = 1'b1;
        send(3'b001, 16'h00FF, 5'd25, 32'h000000FF, 1'b0);
        total++;
        if ({out_valid, out_imm, out_tag, acc_cnt} !== {1'b1, 32'h000000FF, 5'd25, 16'd1}) begin
            bad++;
            $display("FAIL post_reset: got v=%b %h/%0d cnt=%0d required v=1 000000ff/25 cnt=1", out_valid, out_imm, out_tag, acc_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_ops();
        test_err();
        test_backpressure();
        test_stream();
        test_cnt_wrap();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width; legal range 2..OUT_W-1.
REQ-002 Parameter OUT_W, default 32, extended output width.
REQ-003 Parameter TAG_W, default 5, width of the sideband tag carried with each item.
REQ-004 Parameter CNT_W, default 16, width of the accepted-item counter.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  reset, asynchronous and active-high.
REQ-007 flush  input  1  synchronous discard of all held items.
REQ-008 in_valid  input  1  upstream item present.
REQ-009 in_ready  output  1  block can accept an item this cycle.
REQ-010 in_imm  input  IN_W  raw immediate.
REQ-011 in_op  input  3  extension mode.
REQ-012 in_tag  input  TAG_W  sideband tag, passed through unchanged.
REQ-013 out_valid  output  1  extended item present.
REQ-014 out_ready  input  1  downstream accepts the item this cycle.
REQ-015 out_imm  output  OUT_W  extended immediate.
REQ-016 out_tag  output  TAG_W  tag of the item on out_imm.
REQ-017 out_err  output  1  item was issued with a reserved op.
REQ-018 acc_cnt  output  CNT_W  count of accepted items.

Function
REQ-019 Extension modes SHALL be as follows:
- 000: sign-extend.
- 001: zero-extend.
- 010: upper, {in_imm, (OUT_W-IN_W) zeros}.
- 011: sign-extend, then shift left 2 (branch offset); the top 2 bits are dropped.
- 100: ones-extend, with the upper bits filled with 1.
- 101: sign-extend, then shift left 1.
REQ-020 Ops 110 and 111 SHALL produce the sign-extended result with out_err=1; all other ops SHALL produce out_err=0.
REQ-021 Extension SHALL be computed combinationally at the input; the result, tag and err bit are stored together as one item.
REQ-022 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-023 The block SHALL hold at most 2 items: an output register plus a 1-entry skid buffer.
REQ-024 in_ready SHALL equal !skid_full; it is registered and does not depend combinationally on out_ready.
REQ-025 Latency SHALL be 1 cycle: an item accepted at edge N is visible on out_* after edge N when the output register is empty or draining.
REQ-026 On input transfer:
- Output register empty, or draining this cycle: the item loads into the output register.
- Otherwise: the item loads into the skid buffer.
REQ-027 On output transfer with the skid buffer full, the skid item SHALL move to the output register in the same edge, and the skid buffer becomes empty.
REQ-028 On simultaneous input and output transfer with a full skid buffer: the skid item moves to the output register, and the new item goes to the skid buffer (in_ready was 0, so this case cannot occur; a bench SHALL check it never happens).
REQ-029 Items SHALL leave in acceptance order; no item is dropped or duplicated.
REQ-030 While out_valid=1 && out_ready=0, out_imm, out_tag and out_err SHALL hold stable.
REQ-031 acc_cnt SHALL increment by 1 on each input transfer and wrap modulo 2^CNT_W.
REQ-032 flush=1 SHALL clear out_valid and the skid buffer at the next edge and ignore the concurrent input transfer; acc_cnt still counts a handshake that occurs during flush; in_ready=1 after the edge.
REQ-033 out_imm and out_tag SHALL be don't-care while out_valid=0, but MUST NOT be X after reset.

Reset
REQ-034 Reset assertion SHALL immediately set out_valid=0, skid empty, in_ready=1, out_imm=0, out_tag=0, out_err=0, acc_cnt=0, without waiting for a clock edge.
REQ-035 Reset mid-transfer SHALL discard all held items; the first item after reset release SHALL be treated as a fresh acceptance.
REQ-036 Reset deassertion SHALL take effect synchronously; the first input transfer is possible on the first edge after release.

Verification
REQ-037 Defaults, out_ready=1: ops 000..101 with in_imm=16'h8001 SHALL give FFFF8001, 00008001, 80010000, FFFE0004, FFFF8001, FFFF0002, each with out_err=0, 1 cycle after acceptance.
REQ-038 op=110 and op=111 with in_imm=16'h7FFF SHALL give out_imm=00007FFF with out_err=1.
REQ-039 Backpressure: out_ready=0, in_valid=1, three items with tags 1,2,3:
- Tags 1 and 2 are accepted, and in_ready=0 from the edge after tag 2.
- Tag 3 is held upstream.
- Releasing out_ready yields tags 1,2,3 in order, with output stable while stalled.
REQ-040 Streaming: in_valid=out_ready=1 for 100 cycles SHALL give 100 items at full throughput, in order; acc_cnt=100.
REQ-041 Set CNT_W=4 and accept 17 items; acc_cnt SHALL equal 1.
REQ-042 Flush and reset with 2 items held:
- flush pulse: out_valid=0 and in_ready=1 after the edge.
- Repeat with an asynchronous reset pulse between edges: all outputs are zero immediately.
